// File: rtl/ein_pkg.sv
// Shared EIN definitions: receiver state encoding, pad line indices
// (common with the EIN transmit path) and a small edge helper.
package ein_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RX    = 2'd1,
    ST_DRAIN = 2'd2
  } ein_state_t;

  localparam int EIN_LINE_EMO  = 0;
  localparam int EIN_LINE_EDI  = 1;
  localparam int EIN_LINE_ECI  = 2;
  localparam int EIN_NUM_LINES = 3;

  // A line has an edge in the cycle its value differs from the delayed copy.
  function automatic logic is_edge(input logic cur, input logic prev);
    return cur ^ prev;
  endfunction

endpackage

// File: rtl/ein_sync_filter.sv
// Two-flop synchronizer for one asynchronous EIN pad line, followed by an
// optional glitch filter (macro EIN_RX_GLITCH_FILTER_EN). With the filter,
// the output only moves after FILTER_LEN consecutive identical samples.
module ein_sync_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic line
);

  logic meta;
  logic sync;

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("ein_sync_filter: FILTER_LEN must be at least 1");
  end

  // Metastability guard: two flops in series.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= pad;
      sync <= meta;
    end
  end

`ifdef EIN_RX_GLITCH_FILTER_EN
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CW-1:0] run_cnt;
  logic          filt;

  // Count how long the synchronized value has disagreed with the filtered
  // value; adopt it once it has been stable for FILTER_LEN samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
      filt    <= 1'b0;
    end else if (sync == filt) begin
      run_cnt <= '0;
    end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
      run_cnt <= '0;
      filt    <= sync;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  assign line = filt;
`else
  assign line = sync;
`endif

endmodule

// File: rtl/ein_rx.sv
// EIN receiver: frames are opened by an EMO rise and closed by an EMO fall;
// each ECI edge inside a frame shifts one EDI bit in, MSB first. A stall of
// TIMEOUT cycles between ECI edges aborts the frame into DRAIN until EMO
// drops. Optional glitch filter on the pad lines: EIN_RX_GLITCH_FILTER_EN.
//
// state    | meaning
// ST_IDLE  | no frame open, waiting for EMO rise
// ST_RX    | frame open, collecting bits on ECI edges
// ST_DRAIN | frame aborted by timeout, waiting for EMO low
module ein_rx
  import ein_pkg::*;
#(
  parameter int TIMEOUT    = 4000,
  parameter int TO_WIDTH   = 12,
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       EMO_IN,
  input  logic       EDI_IN,
  input  logic       ECI_IN,
  output logic [7:0] out_data,
  output logic       out_data_valid,
  output logic       out_frame_valid,
  output logic       out_frame_error
);

  if (TIMEOUT < 2 || TIMEOUT >= (1 << TO_WIDTH)) begin : g_bad_timeout
    $error("ein_rx: TIMEOUT must be >= 2 and fit in TO_WIDTH bits");
  end

  // The error strobe becomes visible one cycle after the terminal count, so
  // the load value is chosen to land that strobe TIMEOUT cycles after the
  // last ECI edge.
  localparam logic [TO_WIDTH-1:0] TO_LOAD = TO_WIDTH'(TIMEOUT - 2);

  logic [EIN_NUM_LINES-1:0] pad_vec;
  logic [EIN_NUM_LINES-1:0] line_vec;

  assign pad_vec[EIN_LINE_EMO] = EMO_IN;
  assign pad_vec[EIN_LINE_EDI] = EDI_IN;
  assign pad_vec[EIN_LINE_ECI] = ECI_IN;

  for (genvar i = 0; i < EIN_NUM_LINES; i++) begin : g_line
    ein_sync_filter #(
      .FILTER_LEN(FILTER_LEN)
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .pad  (pad_vec[i]),
      .line (line_vec[i])
    );
  end

  logic emo_s, edi_s, eci_s;
  logic emo_d, eci_d;
  logic emo_rise, emo_fall, eci_edge;

  assign emo_s = line_vec[EIN_LINE_EMO];
  assign edi_s = line_vec[EIN_LINE_EDI];
  assign eci_s = line_vec[EIN_LINE_ECI];

  // One-cycle delayed copies for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      emo_d <= 1'b0;
      eci_d <= 1'b0;
    end else begin
      emo_d <= emo_s;
      eci_d <= eci_s;
    end
  end

  assign emo_rise = is_edge(emo_s, emo_d) & emo_s;
  assign emo_fall = is_edge(emo_s, emo_d) & ~emo_s;
  assign eci_edge = is_edge(eci_s, eci_d);

  ein_state_t          state, state_nxt;
  logic [6:0]          shift_q;
  logic [2:0]          bit_cnt;
  logic [TO_WIDTH-1:0] to_cnt;

  logic load_to;
  logic shift_en;
  logic clr_bits;
  logic byte_done;
  logic err_set;
  logic to_done;

  assign to_done = (to_cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath controls; an EMO fall outranks a coincident ECI
  // edge, and a fresh ECI edge outranks an expiring timeout.
  always_comb begin
    state_nxt = state;
    load_to   = 1'b0;
    shift_en  = 1'b0;
    clr_bits  = 1'b0;
    byte_done = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (emo_rise) begin
          state_nxt = ST_RX;
          load_to   = 1'b1;
          clr_bits  = 1'b1;
        end
      end
      ST_RX: begin
        if (emo_fall) begin
          state_nxt = ST_IDLE;
          clr_bits  = 1'b1;
          err_set   = (bit_cnt != 3'd0);
        end else if (eci_edge) begin
          shift_en  = 1'b1;
          load_to   = 1'b1;
          byte_done = (bit_cnt == 3'd7);
        end else if (to_done) begin
          state_nxt = ST_DRAIN;
          clr_bits  = 1'b1;
          err_set   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!emo_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shift register, bit count, timeout down-counter and output strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q         <= '0;
      bit_cnt         <= '0;
      to_cnt          <= '0;
      out_data        <= 8'h00;
      out_data_valid  <= 1'b0;
      out_frame_error <= 1'b0;
    end else begin
      out_data_valid  <= byte_done;
      out_frame_error <= err_set;

      if (clr_bits) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (shift_en) begin
        shift_q <= {shift_q[5:0], edi_s};
      end

      if (byte_done) begin
        out_data <= {shift_q, edi_s};
      end

      if (load_to) begin
        to_cnt <= TO_LOAD;
      end else if (state == ST_RX && !to_done) begin
        to_cnt <= to_cnt - 1'b1;
      end
    end
  end

  assign out_frame_valid = (state == ST_RX);

endmodule

// File: tb/tb_ein_rx.sv
// Directed bench for ein_rx: a table of frames with hand-computed bytes and
// error expectations, plus hand sequences for timeout/DRAIN, an ECI edge
// coincident with EMO fall, a short ECI glitch and a mid-frame reset.
module tb_ein_rx;
  import ein_pkg::*;

  localparam int TO = 4000;
  localparam int FL = 3;
`ifdef EIN_RX_GLITCH_FILTER_EN
  localparam int LAT_EXTRA = FL;
`else
  localparam int LAT_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       emo, edi, eci;
  logic [7:0] out_data;
  logic       out_data_valid, out_frame_valid, out_frame_error;

  ein_rx #(.TIMEOUT(TO), .TO_WIDTH(12), .FILTER_LEN(FL)) dut (
    .clk            (clk),
    .reset          (reset),
    .EMO_IN         (emo),
    .EDI_IN         (edi),
    .ECI_IN         (eci),
    .out_data       (out_data),
    .out_data_valid (out_data_valid),
    .out_frame_valid(out_frame_valid),
    .out_frame_error(out_frame_error)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  logic [7:0] rx_q[$];
  int         err_cnt  = 0;
  int         err_cyc  = 0;
  int         viol     = 0;
  logic       prev_fv  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record strobes; a strobe outside a frame, or an error strobe that does
  // not coincide with the frame closing, is counted as a violation.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_data_valid) begin
        rx_q.push_back(out_data);
        if (!out_frame_valid) viol++;
      end
      if (out_frame_error) begin
        err_cnt++;
        err_cyc = cyc;
        if (!(prev_fv && !out_frame_valid)) viol++;
      end
      prev_fv = out_frame_valid;
    end else begin
      prev_fv = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic send_bits(input int n, input logic [31:0] bits, input int half);
    for (int i = 0; i < n; i++) begin
      edi = bits[31-i];
      wait_cyc(half / 2);
      eci = ~eci;
      wait_cyc(half - half / 2);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    err_cnt = 0;
    viol    = 0;
  endtask

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    int          half;
    int          exp_n;
    logic [7:0]  exp_b[3];
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16, 32'hA53C_0000, 100, 2, '{8'hA5, 8'h3C, 8'h00}, 1'b0};
    vecs[1] = '{11, 32'h5AA0_0000, 10,  1, '{8'h5A, 8'h00, 8'h00}, 1'b1};
    vecs[2] = '{8,  32'h0000_0000, 10,  1, '{8'h00, 8'h00, 8'h00}, 1'b0};
    vecs[3] = '{0,  32'h0000_0000, 10,  0, '{8'h00, 8'h00, 8'h00}, 1'b0};
    vecs[4] = '{1,  32'h8000_0000, 10,  0, '{8'h00, 8'h00, 8'h00}, 1'b1};
    vecs[5] = '{24, 32'h0180_C300, 10,  3, '{8'h01, 8'h80, 8'hC3}, 1'b0};
    vecs[6] = '{7,  32'hFE00_0000, 10,  0, '{8'h00, 8'h00, 8'h00}, 1'b1};

    reset = 1'b1;
    emo = 1'b0; edi = 1'b0; eci = 1'b0;
    wait_cyc(3);
    check("rst_data",  32'(out_data), 32'h00);
    check("rst_dv",    32'(out_data_valid), 0);
    check("rst_fv",    32'(out_frame_valid), 0);
    check("rst_err",   32'(out_frame_error), 0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    reset = 1'b0;
    wait_cyc(5);

    for (int v = 0; v < 7; v++) begin
      clear_mon();
      emo = 1'b1;
      wait_cyc(10);
      check($sformatf("v%0d_fv_open", v), 32'(out_frame_valid), 1);
      send_bits(vecs[v].nbits, vecs[v].bits, vecs[v].half);
      check($sformatf("v%0d_fv_span", v), 32'(out_frame_valid), 1);
      emo = 1'b0;
      wait_cyc(20);
      check($sformatf("v%0d_nbytes", v), 32'(rx_q.size()), 32'(vecs[v].exp_n));
      for (int b = 0; b < vecs[v].exp_n; b++) begin
        if (b < rx_q.size())
          check($sformatf("v%0d_byte%0d", v, b), 32'(rx_q[b]), 32'(vecs[v].exp_b[b]));
      end
      check($sformatf("v%0d_err", v), 32'(err_cnt), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_fv_closed", v), 32'(out_frame_valid), 0);
      check($sformatf("v%0d_viol", v), 32'(viol), 0);
    end

    // Timeout: three bits, then ECI stalls.
    begin
      int t0;
      int waited;
      clear_mon();
      emo = 1'b1;
      wait_cyc(10);
      for (int i = 0; i < 3; i++) begin
        edi = i[0];
        wait_cyc(3);
        eci = ~eci;
        t0 = cyc;
        if (i < 2) wait_cyc(3);
      end
      waited = 0;
      while (err_cnt == 0 && waited < TO + 200) begin
        @(negedge clk);
        waited++;
      end
      check("to_err_seen", 32'(err_cnt), 1);
      if (err_cnt == 1) begin
        n_checks++;
        if (err_cyc - t0 < TO + 1 + LAT_EXTRA || err_cyc - t0 > TO + 3 + LAT_EXTRA) begin
          n_err++;
          $display("FAIL to_delay: got %0d expected %0d..%0d", err_cyc - t0,
                   TO + 1 + LAT_EXTRA, TO + 3 + LAT_EXTRA);
        end
      end
      wait_cyc(2);
      check("to_state_drain", 32'(dut.state), 32'(ST_DRAIN));
      check("to_fv_low", 32'(out_frame_valid), 0);
      edi = 1'b1;
      for (int i = 0; i < 10; i++) begin
        eci = ~eci;
        wait_cyc(8);
      end
      check("drain_state", 32'(dut.state), 32'(ST_DRAIN));
      check("drain_nbytes", 32'(rx_q.size()), 0);
      check("drain_err", 32'(err_cnt), 1);
      emo = 1'b0;
      wait_cyc(12);
      check("drain_exit", 32'(dut.state), 32'(ST_IDLE));
      check("to_viol", 32'(viol), 0);
    end

    // ECI edge coincident with EMO fall right after a full byte.
    clear_mon();
    emo = 1'b1;
    wait_cyc(10);
    send_bits(8, 32'h9600_0000, 10);
    eci = ~eci;
    emo = 1'b0;
    wait_cyc(20);
    check("coin_nbytes", 32'(rx_q.size()), 1);
    if (rx_q.size() > 0) check("coin_byte", 32'(rx_q[0]), 32'h96);
    check("coin_err", 32'(err_cnt), 0);

    // Two-cycle ECI glitch in the middle of a frame.
    clear_mon();
    emo = 1'b1;
    wait_cyc(10);
    send_bits(3, 32'hA000_0000, 10);
    edi = 1'b1;
    wait_cyc(5);
    eci = ~eci;
    wait_cyc(2);
    eci = ~eci;
    wait_cyc(10);
    send_bits(5, 32'hC800_0000, 10);
    emo = 1'b0;
    wait_cyc(20);
    check("glitch_nbytes", 32'(rx_q.size()), 1);
`ifdef EIN_RX_GLITCH_FILTER_EN
    if (rx_q.size() > 0) check("glitch_byte", 32'(rx_q[0]), 32'hB9);
    check("glitch_err", 32'(err_cnt), 0);
`else
    if (rx_q.size() > 0) check("glitch_byte", 32'(rx_q[0]), 32'hBE);
    check("glitch_err", 32'(err_cnt), 1);
`endif

    // Reset after five bits, then a clean 8'hFF frame.
    clear_mon();
    emo = 1'b1;
    wait_cyc(10);
    send_bits(5, 32'hD000_0000, 10);
    reset = 1'b1;
    emo   = 1'b0;
    wait_cyc(1);
    check("mid_rst_data",  32'(out_data), 32'h00);
    check("mid_rst_fv",    32'(out_frame_valid), 0);
    check("mid_rst_dv",    32'(out_data_valid), 0);
    check("mid_rst_err",   32'(out_frame_error), 0);
    check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(10);
    check("post_rst_err", 32'(err_cnt), 0);
    clear_mon();
    emo = 1'b1;
    wait_cyc(10);
    send_bits(8, 32'hFF00_0000, 10);
    emo = 1'b0;
    wait_cyc(20);
    check("ff_nbytes", 32'(rx_q.size()), 1);
    if (rx_q.size() > 0) check("ff_byte", 32'(rx_q[0]), 32'hFF);
    check("ff_err", 32'(err_cnt), 0);
    check("ff_viol", 32'(viol), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ein_rx.md
EIN_RX -- requirements
Module: ein_rx

Interface
REQ-001 Parameter TIMEOUT, default 4000, meaning max clk cycles between ECI edges while a frame is open.
REQ-002 Parameter TO_WIDTH, default 12, meaning timeout counter width; TIMEOUT SHALL fit in TO_WIDTH bits.
REQ-003 Parameter FILTER_LEN, default 3, meaning consecutive equal samples required by the glitch filter.
REQ-004 Port clk  input  1  sole clock; all state on posedge clk.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Ports EMO_IN, EDI_IN, ECI_IN  input  1 each  asynchronous EIN pad lines.
REQ-007 Port out_data  output  8  received byte.
REQ-008 Port out_data_valid  output  1  one-cycle strobe qualifying out_data.
REQ-009 Port out_frame_valid  output  1  high while a frame is open.
REQ-010 Port out_frame_error  output  1  one-cycle strobe on timeout or partial final byte.

Function
REQ-011 Each pad line SHALL pass a two-flop synchronizer; all logic SHALL use synchronized values only.
REQ-012 Edge detect: an edge SHALL be the cycle in which the synchronized value differs from its one-cycle-delayed copy.
REQ-013 States: IDLE, RX, DRAIN; reset state IDLE.
REQ-014 IDLE -> RX on EMO rising edge; out_frame_valid SHALL assert the following cycle, bit count cleared to 0.
REQ-015 In RX, each ECI edge (either direction) SHALL shift synchronized EDI into the shift register, MSB first, and increment the 3-bit bit count.
REQ-016 On the 8th bit, out_data SHALL present the byte and out_data_valid SHALL pulse for exactly one cycle, the cycle after the edge; bit count wraps to 0.
REQ-017 out_data SHALL hold its last value between strobes.
REQ-018 RX -> IDLE on EMO falling edge; out_frame_valid SHALL deassert the following cycle.
REQ-019 If bit count is non-zero at EMO fall, out_frame_error SHALL pulse in the same cycle out_frame_valid deasserts; partial bits are discarded.
REQ-020 ECI edge in the same cycle as EMO falling edge SHALL be ignored.
REQ-021 Timeout counter SHALL reset on entry to RX and on every ECI edge; on reaching TIMEOUT, out_frame_error pulses, out_frame_valid deasserts next cycle, state -> DRAIN.
REQ-022 DRAIN SHALL ignore ECI/EDI and return to IDLE once synchronized EMO is low.
REQ-023 EMO rising edge while not in IDLE SHALL be ignored.
REQ-024 out_data_valid and out_frame_error SHALL never assert outside a frame except the closing-cycle error strobe of REQ-019/021.

Reset
REQ-025 Reset SHALL clear synchronizers, edge registers, shift register, bit count, timeout counter and filter counters.
REQ-026 Reset values: out_data 8'h00, out_data_valid 0, out_frame_valid 0, out_frame_error 0, state IDLE.
REQ-027 Reset mid-frame SHALL abandon the frame with no error strobe; a frame resumes only on a fresh EMO rise.

Configuration
REQ-028 Macro EIN_RX_GLITCH_FILTER_EN defined: each synchronized line SHALL update its filtered value only after FILTER_LEN consecutive identical samples, adding FILTER_LEN cycles latency.
REQ-029 Macro EIN_RX_GLITCH_FILTER_EN undefined: filter removed; edge detection operates directly on synchronizer outputs.

Structure
REQ-030 Shared package ein_pkg SHALL hold the state encoding constants and the EIN line-index constants shared with the EIN transmit path.
REQ-031 Synchronizer plus optional filter SHALL be one sub-module, ein_sync_filter, instanced three times.

Verification
REQ-032 Frame of bytes 8'hA5, 8'h3C with ECI period 200 cycles -> two out_data_valid strobes with 8'hA5 then 8'h3C, out_frame_valid spans both, no error.
REQ-033 Frame of 11 ECI edges then EMO fall -> one byte strobe, out_frame_error pulses with out_frame_valid fall.
REQ-034 EMO high, 3 bits, ECI stalled 4000 cycles -> out_frame_error at cycle 4000 after last edge, state DRAIN until EMO low, no byte strobe.
REQ-035 ECI edge coincident with EMO fall after 8 bits in the prior byte -> edge ignored, no error strobe.
REQ-036 With EIN_RX_GLITCH_FILTER_EN, 2-cycle ECI pulse mid-frame -> no bit captured; without macro -> two bits captured.
REQ-037 Reset asserted after 5 bits -> all outputs at reset values next cycle; subsequent clean frame of 8'hFF received correctly.
